tx_word_seq: RTL



---
 rtl/tx_word_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tx_word_seq.sv
// Transmit sequencer: captures an NUM_BYTES-wide word and feeds it byte by byte to serial8.
// Define TX_GAP_EN to insert GAP_CYCLES idle cycles between consecutive bytes.
module tx_word_seq #(
  parameter int NUM_BYTES  = 2,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 4,
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trmt,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  input  logic                   byte_sent,
  output logic                   send_byte,
  output logic [7:0]             tx_byte,
  output logic [IDX_W-1:0]       byte_idx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  if (NUM_BYTES < 1 || NUM_BYTES > 16 || GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_param_chk
    $error("tx_word_seq: parameter out of range");
  end

`ifdef TX_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;
  logic [7:0] gap_cnt, gap_cnt_nxt;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
`endif

  state_t                      state, state_nxt;
  logic [NUM_BYTES-1:0][7:0]   shadow, shadow_nxt;
  logic                        send_nxt, done_nxt, busy_nxt;
  logic [7:0]                  byte_nxt;
  logic [IDX_W-1:0]            idx_nxt, sel_idx;
  logic                        last_byte;

  // transmit-order index mapped to the physical byte lane of the shadow word
  assign sel_idx   = MSB_FIRST ? (IDX_W'(NUM_BYTES - 1) - byte_idx) : byte_idx;
  assign last_byte = (byte_idx == IDX_W'(NUM_BYTES - 1));

  always_comb begin
    state_nxt  = state;
    send_nxt   = 1'b0;
    done_nxt   = 1'b0;
    busy_nxt   = tx_busy;
    byte_nxt   = tx_byte;
    idx_nxt    = byte_idx;
    shadow_nxt = shadow;
`ifdef TX_GAP_EN
    gap_cnt_nxt = gap_cnt;
`endif
    case (state)
      IDLE: begin
        idx_nxt  = '0;
        busy_nxt = trmt;
        if (trmt) begin
          shadow_nxt = tx_data;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        send_nxt  = 1'b1;
        byte_nxt  = shadow[sel_idx];
        busy_nxt  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (byte_sent) begin
          if (last_byte) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = byte_idx + IDX_W'(1);
`ifdef TX_GAP_EN
            gap_cnt_nxt = 8'(GAP_CYCLES - 1);
            state_nxt   = GAP;
`else
            state_nxt   = SEND;
`endif
          end
        end
      end
`ifdef TX_GAP_EN
      GAP: begin
        if (gap_cnt == 8'd0) state_nxt = SEND;
        else                 gap_cnt_nxt = gap_cnt - 8'd1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // all outputs leave flops; tx_busy drops the cycle after tx_done
  always_ff @(posedge clk) begin
    if (rst) begin
      send_byte <= 1'b0;
      tx_done   <= 1'b0;
      tx_busy   <= 1'b0;
      tx_byte   <= 8'h00;
      byte_idx  <= '0;
      shadow    <= '0;
    end else begin
      send_byte <= send_nxt;
      tx_done   <= done_nxt;
      tx_busy   <= busy_nxt;
      tx_byte   <= byte_nxt;
      byte_idx  <= idx_nxt;
      shadow    <= shadow_nxt;
    end
  end

`ifdef TX_GAP_EN
  always_ff @(posedge clk) begin
    if (rst) gap_cnt <= 8'd0;
    else     gap_cnt <= gap_cnt_nxt;
  end
`endif

endmodule
